pixel_frame_sequencer: RTL and testbench

Parametrised frame sequencer for the image-sensor pixel array. It runs the erase → expose → convert → readout cycle and shares one ADC ramp counter across the array. Converted codes are read out row by row, column by column, onto the shared tristate pixel data bus, with a valid/ready handshake. It generalises the fixed-size top-level sequencer with:
- configurable array size, ADC resolution and bus width;
- a runtime exposure time;
- consumer back-pressure.

---
 rtl/pixel_pkg.sv | 18 +
 rtl/pixel_frame_sequencer_if.sv | 11 +
 rtl/pixel_bus_driver.sv | 31 +++
 rtl/pixel_frame_sequencer.sv | 159 +++++++++++++++
 tb/tb_pixel_frame_sequencer.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_pkg.sv
// Shared types and width helpers for the pixel frame sequencer.
package pixel_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_SETTLE,
    S_READ
  } state_t;

  // Bits needed to count 0..n-1; never returns less than 1.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pixel_frame_sequencer_if.sv
// Readout handshake between the frame sequencer and the pixel consumer.
// dataValid rises independently of rdReady and stays high, with the bus word
// stable, until a cycle where rdReady=1; the word transfers on that clock edge.
interface pixel_frame_sequencer_if;
  logic dataValid;
  logic rdReady;
  logic frameDone;

  modport master (output dataValid, output frameDone, input rdReady);
  modport slave  (input dataValid, input frameDone, output rdReady);
endinterface

// File: rtl/pixel_bus_driver.sv
// Column mux onto the shared pixel bus: zero-extends the selected code and
// drives the bus only while a word is valid.
module pixel_bus_driver
  import pixel_pkg::*;
#(
  parameter int COLS     = 4,
  parameter int ADC_BITS = 8,
  parameter int BUS_W    = 16
) (
  input  logic [cnt_w(COLS)-1:0]    col,
  input  logic [COLS*ADC_BITS-1:0]  colData,
  input  logic                      dataValid,
  inout  wire  [BUS_W-1:0]          pixelDataOut
);

  localparam int CW = cnt_w(COLS);

  logic [ADC_BITS-1:0] code;
  logic [BUS_W-1:0]    word;

  always_comb begin
    code = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col == CW'(c)) code = colData[c*ADC_BITS +: ADC_BITS];
    end
  end

  assign word         = BUS_W'(code);
  assign pixelDataOut = dataValid ? word : {BUS_W{1'bz}};

endmodule

// File: rtl/pixel_frame_sequencer.sv
// Erase/expose/convert/readout sequencer with a shared ADC ramp and a
// valid/ready pixel readout onto a tristate bus.
module pixel_frame_sequencer
  import pixel_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int ADC_BITS = 8,
  parameter int BUS_W    = 16,
  parameter int C_ERASE  = 5,
  parameter int EXP_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic [EXP_W-1:0]          expTime,
  input  logic [COLS*ADC_BITS-1:0]  colData,
  output logic                      erase,
  output logic                      expose,
  output logic                      convert,
  output logic [ADC_BITS-1:0]       adcCode,
  output logic [ROWS-1:0]           rowSel,
  inout  wire  [BUS_W-1:0]          pixelDataOut,
  pixel_frame_sequencer_if.master   hs,
  output state_t                    state_dbg
);

  localparam int RW = cnt_w(ROWS);
  localparam int CW = cnt_w(COLS);
  localparam int EW = cnt_w(C_ERASE);
  // One down-counter times both ERASE and EXPOSE, so it must hold either.
  localparam int TW = (EXP_W > EW) ? EXP_W : EW;

  state_t              state, state_nxt;
  logic [TW-1:0]       timer, timer_nxt;
  logic [ADC_BITS-1:0] adc, adc_nxt;
  logic [RW-1:0]       row, row_nxt;
  logic [CW-1:0]       col, col_nxt;
  logic [EXP_W-1:0]    exp_lat, exp_nxt;
  logic                done_q, done_nxt;
  logic                xfer;
  logic [TW-1:0]       expose_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      timer   <= '0;
      adc     <= '0;
      row     <= '0;
      col     <= '0;
      exp_lat <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      adc     <= adc_nxt;
      row     <= row_nxt;
      col     <= col_nxt;
      exp_lat <= exp_nxt;
      done_q  <= done_nxt;
    end
  end

  // An exposure of 0 is run as a single cycle.
  assign expose_load = (exp_lat == '0) ? '0 : TW'(exp_lat - 1'b1);
  assign xfer        = (state == S_READ) && hs.rdReady;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    adc_nxt   = adc;
    row_nxt   = row;
    col_nxt   = col;
    exp_nxt   = exp_lat;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) begin
          state_nxt = S_ERASE;
          timer_nxt = TW'(C_ERASE - 1);
          exp_nxt   = expTime;
        end
      end
      S_ERASE: begin
        if (timer == '0) begin
          state_nxt = S_EXPOSE;
          timer_nxt = expose_load;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      S_EXPOSE: begin
        if (timer == '0) begin
          state_nxt = S_CONVERT;
          adc_nxt   = '0;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      S_CONVERT: begin
        if (adc == '1) begin
          state_nxt = S_SETTLE;
          adc_nxt   = '0;
          row_nxt   = '0;
        end else begin
          adc_nxt = adc + 1'b1;
        end
      end
      S_SETTLE: begin
        state_nxt = S_READ;
        col_nxt   = '0;
      end
      S_READ: begin
        if (xfer) begin
          if (col != CW'(COLS - 1)) begin
            col_nxt = col + 1'b1;
          end else if (row != RW'(ROWS - 1)) begin
            row_nxt   = row + 1'b1;
            state_nxt = S_SETTLE;
          end else begin
            // Frame complete: run is only looked at here and in IDLE.
            done_nxt = 1'b1;
            row_nxt  = '0;
            col_nxt  = '0;
            if (run) begin
              state_nxt = S_ERASE;
              timer_nxt = TW'(C_ERASE - 1);
              exp_nxt   = expTime;
            end else begin
              state_nxt = S_IDLE;
            end
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign erase        = (state == S_ERASE);
  assign expose       = (state == S_EXPOSE);
  assign convert      = (state == S_CONVERT);
  assign adcCode      = adc;
  assign rowSel       = ((state == S_SETTLE) || (state == S_READ)) ? (ROWS'(1) << row) : '0;
  assign hs.dataValid = (state == S_READ);
  assign hs.frameDone = done_q;
  assign state_dbg    = state;

  pixel_bus_driver #(
    .COLS     (COLS),
    .ADC_BITS (ADC_BITS),
    .BUS_W    (BUS_W)
  ) u_bus_driver (
    .col          (col),
    .colData      (colData),
    .dataValid    (hs.dataValid),
    .pixelDataOut (pixelDataOut)
  );

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Randomised frame-level bench: a small pixel array model feeds colData and a
// row-major word list is the expected readout for each frame.
module tb_pixel_frame_sequencer;
  import pixel_pkg::*;

  localparam int ROWS     = 2;
  localparam int COLS     = 2;
  localparam int ADC_BITS = 4;
  localparam int BUS_W    = 16;
  localparam int C_ERASE  = 5;
  localparam int EXP_W    = 16;
  localparam int NCODES   = 1 << ADC_BITS;
  localparam int NWORDS   = ROWS * COLS;

  // ---------------- clock / reset / DUT ----------------
  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     run = 1'b0;
  logic [EXP_W-1:0]         expTime = '0;
  logic [COLS*ADC_BITS-1:0] colData;
  logic                     erase, expose, convert;
  logic [ADC_BITS-1:0]      adcCode;
  logic [ROWS-1:0]          rowSel;
  wire  [BUS_W-1:0]         pixelDataOut;
  state_t                   state_dbg;

  pixel_frame_sequencer_if hs_if ();

  // Undriven bus floats high, so a released bus reads all ones.
  pullup (pixelDataOut);

  always #5 clk = ~clk;

  pixel_frame_sequencer #(
    .ROWS (ROWS), .COLS (COLS), .ADC_BITS (ADC_BITS),
    .BUS_W (BUS_W), .C_ERASE (C_ERASE), .EXP_W (EXP_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .expTime      (expTime),
    .colData      (colData),
    .erase        (erase),
    .expose       (expose),
    .convert      (convert),
    .adcCode      (adcCode),
    .rowSel       (rowSel),
    .pixelDataOut (pixelDataOut),
    .hs           (hs_if.slave),
    .state_dbg    (state_dbg)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- pixel array model / scoreboard ----------------
  logic [ADC_BITS-1:0] pix [ROWS][COLS];
  logic [BUS_W-1:0]    exp_q[$];
  logic [ROWS-1:0]     exp_row_q[$];
  int errors = 0;
  int checks = 0;

  always_comb begin
    colData = '0;
    for (int r = 0; r < ROWS; r++)
      if (rowSel[r])
        for (int c = 0; c < COLS; c++) colData[c*ADC_BITS +: ADC_BITS] = pix[r][c];
  end

  // mode 0: random codes, mode 1: all codes at full scale
  task automatic new_frame(input int mode);
    exp_q.delete();
    exp_row_q.delete();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        pix[r][c] = (mode == 1) ? {ADC_BITS{1'b1}} : ADC_BITS'($urandom_range(0, NCODES - 1));
        exp_q.push_back(BUS_W'(pix[r][c]));
        exp_row_q.push_back(ROWS'(1 << r));
      end
  endtask

  // ---------------- driver / observer ----------------
  int                  n_erase, n_expose, n_convert;
  int                  first_expose, first_convert, first_valid, done_cyc;
  int                  adc_bad_outside, hiz_bad, rowsel_bad;
  bit                  timeout, done_valid, done_erase;
  state_t              done_state;
  logic [ADC_BITS-1:0] adc_q[$];
  logic [BUS_W-1:0]    got_q[$];
  logic [ROWS-1:0]     got_row_q[$];
  logic [BUS_W-1:0]    stall_bus_q[$];
  logic [ROWS-1:0]     stall_row_q[$];

  // Pulses run for one sampling edge; returns at the negedge of the first ERASE cycle.
  task automatic start_frame(input logic [EXP_W-1:0] e, input logic keep_run);
    @(negedge clk);
    run     = 1'b1;
    expTime = e;
    @(negedge clk);
    run = keep_run;
  endtask

  // Observes one frame from the current negedge (cycle 0) until frameDone.
  task automatic observe_frame(input int limit, input int ready_pct,
                               input int stall_idx, input int stall_len);
    int cyc = 0;
    int stall_left = stall_len;
    int nxfer = 0;
    n_erase = 0; n_expose = 0; n_convert = 0;
    first_expose = -1; first_convert = -1; first_valid = -1; done_cyc = -1;
    adc_bad_outside = 0; hiz_bad = 0; rowsel_bad = 0;
    timeout = 1'b1; done_valid = 1'b0; done_erase = 1'b0; done_state = S_IDLE;
    adc_q.delete(); got_q.delete(); got_row_q.delete();
    stall_bus_q.delete(); stall_row_q.delete();
    while (cyc < limit) begin
      if (hs_if.frameDone && cyc > 0) begin
        timeout    = 1'b0;
        done_cyc   = cyc;
        done_valid = hs_if.dataValid;
        done_erase = erase;
        done_state = state_dbg;
        break;
      end
      if (hs_if.dataValid && nxfer == stall_idx && stall_left > 0) begin
        hs_if.rdReady = 1'b0;
        stall_left--;
        stall_bus_q.push_back(pixelDataOut);
        stall_row_q.push_back(rowSel);
      end else begin
        hs_if.rdReady = ($urandom_range(0, 99) < ready_pct);
      end
      if (erase) n_erase++;
      if (expose) begin
        if (first_expose < 0) first_expose = cyc;
        n_expose++;
      end
      if (convert) begin
        if (first_convert < 0) first_convert = cyc;
        n_convert++;
        adc_q.push_back(adcCode);
      end else if (adcCode != '0) adc_bad_outside++;
      if ((erase || expose || convert) && rowSel != '0) rowsel_bad++;
      if (hs_if.dataValid) begin
        if (first_valid < 0) first_valid = cyc;
        if (hs_if.rdReady) begin
          got_q.push_back(pixelDataOut);
          got_row_q.push_back(rowSel);
          nxfer++;
        end
      end else if (pixelDataOut !== {BUS_W{1'b1}}) hiz_bad++;
      @(negedge clk);
      cyc++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({erase, expose, convert, hs_if.dataValid, hs_if.frameDone} !== 5'b0 ||
        adcCode !== '0 || rowSel !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got e%b x%b c%b v%b d%b adc=%h row=%b expected all 0",
               erase, expose, convert, hs_if.dataValid, hs_if.frameDone, adcCode, rowSel);
    end
    checks++;
    if (pixelDataOut !== {BUS_W{1'b1}}) begin
      errors++;
      $display("FAIL reset_bus: got %h expected released bus (%h)", pixelDataOut, {BUS_W{1'b1}});
    end
    checks++;
    if (state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %s expected S_IDLE", state_dbg.name());
    end
    reset = 1'b0;
    hs_if.rdReady = 1'b1;
  endtask

  task automatic test_basic_frame();
    int bad = 0;
    new_frame(0);
    start_frame(16'd10, 1'b0);
    observe_frame(400, 100, -1, 0);
    checks++;
    if (timeout) begin errors++; $display("FAIL basic_timeout: no frameDone within 400 cycles"); end
    checks++;
    if (n_erase != C_ERASE || n_expose != 10 || first_expose != C_ERASE) begin
      errors++;
      $display("FAIL basic_phases: got erase=%0d expose=%0d expose_start=%0d expected %0d/10/%0d",
               n_erase, n_expose, first_expose, C_ERASE, C_ERASE);
    end
    for (int i = 0; i < adc_q.size(); i++) if (adc_q[i] != ADC_BITS'(i)) bad++;
    checks++;
    if (n_convert != NCODES || bad != 0 || adc_bad_outside != 0 || first_convert != C_ERASE + 10) begin
      errors++;
      $display("FAIL basic_ramp: got len=%0d bad_steps=%0d nonzero_outside=%0d start=%0d expected %0d/0/0/%0d",
               n_convert, bad, adc_bad_outside, first_convert, NCODES, C_ERASE + 10);
    end
    checks++;
    if (first_valid != C_ERASE + 10 + NCODES + 1 || done_cyc != C_ERASE + 10 + NCODES + ROWS*(COLS+1)) begin
      errors++;
      $display("FAIL basic_timing: got first_valid=%0d done=%0d expected %0d/%0d", first_valid, done_cyc,
               C_ERASE + 10 + NCODES + 1, C_ERASE + 10 + NCODES + ROWS*(COLS+1));
    end
    checks++;
    if (got_q.size() != NWORDS) begin
      errors++; $display("FAIL basic_count: got %0d words expected %0d", got_q.size(), NWORDS);
    end
    for (int i = 0; i < NWORDS && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_row_q[i] !== exp_row_q[i]) begin
        errors++;
        $display("FAIL basic_word[%0d]: got %h row %b expected %h row %b",
                 i, got_q[i], got_row_q[i], exp_q[i], exp_row_q[i]);
      end
    end
    checks++;
    if (done_valid || done_erase || done_state !== S_IDLE || hiz_bad != 0 || rowsel_bad != 0) begin
      errors++;
      $display("FAIL basic_done: got valid=%b erase=%b state=%s hiz_bad=%0d rowsel_bad=%0d expected 0/0/S_IDLE/0/0",
               done_valid, done_erase, done_state.name(), hiz_bad, rowsel_bad);
    end
    @(negedge clk);
    checks++;
    if (hs_if.frameDone !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse: got frameDone=%b one cycle later expected 0", hs_if.frameDone);
    end
  endtask

  task automatic test_exp_zero();
    new_frame(0);
    start_frame(16'd0, 1'b0);
    observe_frame(400, 100, -1, 0);
    checks++;
    if (timeout || n_expose != 1 || first_convert != C_ERASE + 1) begin
      errors++;
      $display("FAIL exp_zero: got timeout=%b expose=%0d convert_start=%0d expected 0/1/%0d",
               timeout, n_expose, first_convert, C_ERASE + 1);
    end
  endtask

  task automatic test_back_pressure();
    int bad = 0;
    new_frame(0);
    start_frame(16'd4, 1'b0);
    observe_frame(400, 100, 1, 7);
    for (int i = 0; i < stall_bus_q.size(); i++)
      if (stall_bus_q[i] !== exp_q[1] || stall_row_q[i] !== exp_row_q[1]) bad++;
    checks++;
    if (stall_bus_q.size() != 7 || bad != 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d stall cycles, %0d unstable expected 7/0 (word %h row %b)",
               stall_bus_q.size(), bad, exp_q[1], exp_row_q[1]);
    end
    checks++;
    if (timeout || got_q.size() != NWORDS || done_cyc != C_ERASE + 4 + NCODES + ROWS*(COLS+1) + 7) begin
      errors++;
      $display("FAIL bp_count: got timeout=%b words=%0d done=%0d expected 0/%0d/%0d", timeout, got_q.size(),
               done_cyc, NWORDS, C_ERASE + 4 + NCODES + ROWS*(COLS+1) + 7);
    end
    for (int i = 0; i < NWORDS && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_row_q[i] !== exp_row_q[i]) begin
        errors++;
        $display("FAIL bp_word[%0d]: got %h row %b expected %h row %b",
                 i, got_q[i], got_row_q[i], exp_q[i], exp_row_q[i]);
      end
    end
  endtask

  task automatic test_continuous();
    new_frame(0);
    start_frame(16'd3, 1'b1);
    expTime = 16'd9;
    observe_frame(400, 100, -1, 0);
    checks++;
    if (timeout || n_expose != 3 || done_state !== S_ERASE || !done_erase) begin
      errors++;
      $display("FAIL cont_frame1: got timeout=%b expose=%0d state_at_done=%s erase=%b expected 0/3/S_ERASE/1",
               timeout, n_expose, done_state.name(), done_erase);
    end
    for (int i = 0; i < NWORDS && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL cont_word1[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    run = 1'b0;
    new_frame(0);
    observe_frame(400, 100, -1, 0);
    checks++;
    if (timeout || n_erase != C_ERASE || n_expose != 9 || got_q.size() != NWORDS || done_state !== S_IDLE) begin
      errors++;
      $display("FAIL cont_frame2: got timeout=%b erase=%0d expose=%0d words=%0d state=%s expected 0/%0d/9/%0d/S_IDLE",
               timeout, n_erase, n_expose, got_q.size(), done_state.name(), C_ERASE, NWORDS);
    end
    for (int i = 0; i < NWORDS && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL cont_word2[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_width();
    int bad = 0;
    new_frame(1);
    start_frame(16'd2, 1'b0);
    observe_frame(400, 100, -1, 0);
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 16'h000F) bad++;
    checks++;
    if (got_q.size() != NWORDS || bad != 0) begin
      errors++;
      $display("FAIL width_zero_ext: got %0d words, %0d not 16'h000F (first %h) expected %0d/0",
               got_q.size(), bad, (got_q.size() > 0) ? got_q[0] : 16'hxxxx, NWORDS);
    end
  endtask

  task automatic test_reset_mid_read();
    int n = 0;
    new_frame(0);
    start_frame(16'd1, 1'b0);
    hs_if.rdReady = 1'b0;
    while (!hs_if.dataValid && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (!hs_if.dataValid || pixelDataOut !== exp_q[0]) begin
      errors++;
      $display("FAIL rst_pre_read: got valid=%b bus=%h expected 1/%h", hs_if.dataValid, pixelDataOut, exp_q[0]);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (pixelDataOut !== {BUS_W{1'b1}} || hs_if.dataValid !== 1'b0) begin
      errors++;
      $display("FAIL rst_async_bus: got bus=%h valid=%b before next edge expected released/0",
               pixelDataOut, hs_if.dataValid);
    end
    checks++;
    if ({erase, expose, convert, hs_if.frameDone} !== 4'b0 || rowSel !== '0 || adcCode !== '0 ||
        state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL rst_async_outputs: got row=%b adc=%h state=%s expected 0/0/S_IDLE",
               rowSel, adcCode, state_dbg.name());
    end
    @(negedge clk);
    reset = 1'b0;
    hs_if.rdReady = 1'b1;
    new_frame(0);
    start_frame(16'd6, 1'b0);
    observe_frame(400, 100, -1, 0);
    checks++;
    if (timeout || n_erase != C_ERASE || n_expose != 6 || got_q.size() != NWORDS) begin
      errors++;
      $display("FAIL rst_recover: got timeout=%b erase=%0d expose=%0d words=%0d expected 0/%0d/6/%0d",
               timeout, n_erase, n_expose, got_q.size(), C_ERASE, NWORDS);
    end
    for (int i = 0; i < NWORDS && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_row_q[i] !== exp_row_q[i]) begin
        errors++;
        $display("FAIL rst_word[%0d]: got %h row %b expected %h row %b",
                 i, got_q[i], got_row_q[i], exp_q[i], exp_row_q[i]);
      end
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 6; f++) begin
      logic [EXP_W-1:0] e;
      int pct;
      int e_eff;
      e     = EXP_W'($urandom_range(0, 12));
      pct   = int'($urandom_range(30, 100));
      e_eff = (e == '0) ? 1 : int'(e);
      new_frame(0);
      start_frame(e, 1'b0);
      observe_frame(800, pct, -1, 0);
      checks++;
      if (timeout || n_erase != C_ERASE || n_expose != e_eff || n_convert != NCODES ||
          first_valid != C_ERASE + e_eff + NCODES + 1) begin
        errors++;
        $display("FAIL rand%0d_phases: got timeout=%b erase=%0d expose=%0d convert=%0d first_valid=%0d expected 0/%0d/%0d/%0d/%0d",
                 f, timeout, n_erase, n_expose, n_convert, first_valid, C_ERASE, e_eff, NCODES,
                 C_ERASE + e_eff + NCODES + 1);
      end
      checks++;
      if (got_q.size() != NWORDS || done_valid || hiz_bad != 0 || rowsel_bad != 0 || adc_bad_outside != 0) begin
        errors++;
        $display("FAIL rand%0d_frame: got words=%0d done_valid=%b hiz_bad=%0d rowsel_bad=%0d adc_outside=%0d expected %0d/0/0/0/0",
                 f, got_q.size(), done_valid, hiz_bad, rowsel_bad, adc_bad_outside, NWORDS);
      end
      for (int i = 0; i < NWORDS && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i] || got_row_q[i] !== exp_row_q[i]) begin
          errors++;
          $display("FAIL rand%0d_word[%0d]: got %h row %b expected %h row %b",
                   f, i, got_q[i], got_row_q[i], exp_q[i], exp_row_q[i]);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    hs_if.rdReady = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) pix[r][c] = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic_frame();
    test_exp_zero();
    test_back_pressure();
    test_continuous();
    test_width();
    test_reset_mid_read();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
